// File: rtl/fir_pkg.sv
// Shared types and constants for the FIR sample source.
// State encoding, error codes and default widths.
package fir_pkg;

  localparam int DATA_W_DEF    = 16;
  localparam int DEPTH_DEF     = 8;
  localparam int FRAME_LEN_DEF = 64;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_OVERFLOW = 2'b01;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    TAGGED = 2'd2
  } fsm_state_t;

  function automatic logic [7:0] sat_inc8(
    input logic [7:0] v
  );
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/fir_sample_source_if.sv
// Avalon-ST style source bundle for the sample stream.
// master drives data/valid/framing, slave drives ready.
interface fir_sample_source_if
  import fir_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);

  logic [DATA_W-1:0] ast_source_data;
  logic              ast_source_valid;
  logic              ast_source_ready;
  logic [1:0]        ast_source_error;
  logic              ast_source_sop;
  logic              ast_source_eop;

  modport master (
    output ast_source_data,
    output ast_source_valid,
    input  ast_source_ready,
    output ast_source_error,
    output ast_source_sop,
    output ast_source_eop
  );

  modport slave (
    input  ast_source_data,
    input  ast_source_valid,
    output ast_source_ready,
    input  ast_source_error,
    input  ast_source_sop,
    input  ast_source_eop
  );

endinterface

// File: rtl/fir_src_fifo.sv
// First-word fall-through sample FIFO with occupancy count.
// Caller presents only accepted push/pop; storage is not reset.
module fir_src_fifo
  import fir_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [DATA_W-1:0]        i_data,
  output logic [DATA_W-1:0]        o_head,
  output logic                     o_empty,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;

  // sample storage, written on accepted push only
  always_ff @(posedge clk) begin
    if (i_push && !i_flush) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // occupancy: simultaneous push and pop leaves it unchanged
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_flush) begin
      r_count <= '0;
    end else begin
      unique case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_count = r_count;
  assign o_head  = o_empty ? '0 : r_mem[r_rd_ptr];

endmodule

// File: rtl/fir_sample_source.sv
// ADC sample source: FIFO, packet framing, overflow tagging.
// Optional FIR_SRC_CHANGE_DETECT_EN pushes on input change.
module fir_sample_source
  import fir_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int FRAME_LEN = FRAME_LEN_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_W-1:0]   sample_in,
  input  logic                sample_valid,
  input  logic                flush,
  fir_sample_source_if.master src,
  output logic                overflow,
  output logic [7:0]          drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int BW = $clog2(FRAME_LEN);
  localparam logic [BW-1:0] LAST = BW'(FRAME_LEN - 1);

  logic              w_push_req;
  logic [DATA_W-1:0] w_push_data;
  logic              w_push;
  logic              w_pop;
  logic              w_drop;
  logic              w_valid;
  logic              w_empty;
  logic              w_full;
  logic [AW:0]       w_count;
  logic [AW:0]       w_cnt_nxt;
  logic [DATA_W-1:0] w_head;
  logic              w_in_tag;

  logic [BW-1:0]     r_beat;
  logic              r_overflow;
  logic [7:0]        r_drop_cnt;
  fsm_state_t        r_state;
  fsm_state_t        w_state_nxt;

`ifdef FIR_SRC_CHANGE_DETECT_EN
  logic [DATA_W-1:0] r_smp;
  logic [DATA_W-1:0] r_smp_d;
  logic [1:0]        r_hist;
  logic              w_unused_sample_valid;

  // register input and its previous value; r_hist gates
  // comparisons until both registers hold real samples
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_smp   <= '0;
      r_smp_d <= '0;
      r_hist  <= '0;
    end else begin
      r_smp   <= sample_in;
      r_smp_d <= r_smp;
      r_hist  <= {r_hist[0], 1'b1};
    end
  end

  assign w_push_req  = r_hist[1] && (r_smp != r_smp_d);
  assign w_push_data = r_smp;
  assign w_unused_sample_valid = sample_valid;
`else
  assign w_push_req  = sample_valid;
  assign w_push_data = sample_in;
`endif

  assign w_valid = !w_empty;
  assign w_pop   = w_valid && src.ast_source_ready && !flush;
  assign w_push  = w_push_req && (!w_full || w_pop) && !flush;
  assign w_drop  = w_push_req && w_full && !w_pop && !flush;

  assign w_cnt_nxt = w_count
                   + (AW+1)'(w_push)
                   - (AW+1)'(w_pop);

  fir_src_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_flush (flush),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_push_data),
    .o_head  (w_head),
    .o_empty (w_empty),
    .o_full  (w_full),
    .o_count (w_count)
  );

  // beat position within the current packet
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_beat <= '0;
    end else if (flush) begin
      r_beat <= '0;
    end else if (w_pop) begin
      r_beat <= (r_beat == LAST) ? '0 : r_beat + 1'b1;
    end
  end

  // sticky overflow flag and saturating drop counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (flush) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      r_drop_cnt <= sat_inc8(r_drop_cnt);
    end
  end

  assign w_in_tag = !flush && !w_drop && (r_state == TAGGED);

  // next state; the case items are mutually exclusive
  always_comb begin
    w_state_nxt = r_state;
    unique case (1'b1)
      flush: w_state_nxt = IDLE;
      w_drop: w_state_nxt = TAGGED;
      w_in_tag: begin
        if (w_pop) begin
          w_state_nxt = (w_cnt_nxt != '0) ? ACTIVE : IDLE;
        end else begin
          w_state_nxt = TAGGED;
        end
      end
      default: begin
        w_state_nxt = (w_cnt_nxt != '0) ? ACTIVE : IDLE;
      end
    endcase
  end

  // control state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  assign src.ast_source_valid = w_valid;
  assign src.ast_source_data  = w_head;
  assign src.ast_source_sop   = w_valid && (r_beat == '0);
  assign src.ast_source_eop   = w_valid && (r_beat == LAST);
  assign src.ast_source_error =
    (w_valid && r_state == TAGGED) ? ERR_OVERFLOW : ERR_NONE;

  assign overflow   = r_overflow;
  assign drop_count = r_drop_cnt;

endmodule

// File: tb/tb_fir_sample_source.sv
// Self-checking bench for fir_sample_source.
// Vector table, scoreboard monitor and corner sequences.
module tb_fir_sample_source;

  localparam int DW = 16;
  localparam int DEPTH = 8;
  localparam int FL = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] sample_in = '0;
  logic          sample_valid = 1'b0;
  logic          flush = 1'b0;
  logic          overflow;
  logic [7:0]    drop_count;

  fir_sample_source_if #(.DATA_W(DW)) src_if ();

  fir_sample_source #(
    .DATA_W    (DW),
    .DEPTH     (DEPTH),
    .FRAME_LEN (FL)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .flush        (flush),
    .src          (src_if.master),
    .overflow     (overflow),
    .drop_count   (drop_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check(input string name,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               name, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // scoreboard model state
  logic [DW-1:0] q[$];
  int  beat = 0;
  bit  tag = 0;
  bit  m_ovf = 0;
  int  m_dcnt = 0;
  int  n_sop = 0;
  int  n_eop = 0;
  bit  mon_en = 0;

  // monitor: compare outputs, then apply this edge to the model
  initial begin
    bit mpop;
    bit mfull;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (rst) begin
          q.delete();
          beat = 0;
          tag = 0;
          m_ovf = 0;
          m_dcnt = 0;
          check("rst_valid", 32'(src_if.ast_source_valid), 0);
        end else begin
          check("valid", 32'(src_if.ast_source_valid),
                32'(q.size() != 0));
          check("overflow", 32'(overflow), 32'(m_ovf));
          check("drop_count", 32'(drop_count), 32'(m_dcnt));
          mpop = (q.size() != 0) && src_if.ast_source_ready;
          mfull = (q.size() == DEPTH);
          if (flush) begin
            q.delete();
            beat = 0;
            tag = 0;
            m_ovf = 0;
            m_dcnt = 0;
          end else begin
            if (mpop) begin
              check("data", 32'(src_if.ast_source_data), 32'(q[0]));
              check("error", 32'(src_if.ast_source_error),
                    tag ? 32'd1 : 32'd0);
              check("sop", 32'(src_if.ast_source_sop),
                    32'(beat == 0));
              check("eop", 32'(src_if.ast_source_eop),
                    32'(beat == FL - 1));
              if (src_if.ast_source_sop) n_sop++;
              if (src_if.ast_source_eop) n_eop++;
              void'(q.pop_front());
              beat = (beat == FL - 1) ? 0 : beat + 1;
              tag = 0;
            end
            if (sample_valid) begin
              if (!mfull || mpop) begin
                q.push_back(sample_in);
              end else begin
                tag = 1;
                m_ovf = 1;
                if (m_dcnt != 255) m_dcnt++;
              end
            end
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  typedef struct {
    logic          vld;
    logic [DW-1:0] din;
    logic          rdy;
    logic          e_valid;
    logic [DW-1:0] e_data;
    logic          e_sop;
    logic [1:0]    e_err;
  } vec_t;

  vec_t vt[7];

  initial begin
    int n;
    src_if.ast_source_ready = 1'b0;
`ifdef FIR_SRC_CHANGE_DETECT_EN
    mon_en = 0;
    sample_in = 16'h1234;
    repeat (3) step();
    rst = 1'b0;
    repeat (5) step();
    check("cd_hold_valid", 32'(src_if.ast_source_valid), 0);
    sample_in = 16'h1235;
    repeat (4) step();
    check("cd_valid", 32'(src_if.ast_source_valid), 1);
    check("cd_data", 32'(src_if.ast_source_data), 32'h1235);
    check("cd_sop", 32'(src_if.ast_source_sop), 1);
    src_if.ast_source_ready = 1'b1;
    n = 0;
    for (int k = 0; k < 8; k++) begin
      if (src_if.ast_source_valid) n++;
      step();
    end
    check("cd_push_count", 32'(n), 1);
`else
    mon_en = 1;
    repeat (3) step();
    check("rst_valid0", 32'(src_if.ast_source_valid), 0);
    check("rst_error", 32'(src_if.ast_source_error), 0);
    check("rst_data", 32'(src_if.ast_source_data), 0);
    check("rst_sop", 32'(src_if.ast_source_sop), 0);
    check("rst_ovf", 32'(overflow), 0);
    check("rst_dcnt", 32'(drop_count), 0);
    rst = 1'b0;
    step();

    vt[0] = '{1'b1, 16'h0001, 1'b1, 1'b1, 16'h0001, 1'b1, 2'b00};
    vt[1] = '{1'b1, 16'h0002, 1'b1, 1'b1, 16'h0002, 1'b0, 2'b00};
    vt[2] = '{1'b1, 16'h0003, 1'b1, 1'b1, 16'h0003, 1'b0, 2'b00};
    vt[3] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 2'b00};
    vt[4] = '{1'b1, 16'h0055, 1'b0, 1'b1, 16'h0055, 1'b0, 2'b00};
    vt[5] = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0055, 1'b0, 2'b00};
    vt[6] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 2'b00};
    for (int i = 0; i < 7; i++) begin
      sample_valid = vt[i].vld;
      sample_in = vt[i].din;
      src_if.ast_source_ready = vt[i].rdy;
      step();
      check($sformatf("vec%0d_valid", i),
            32'(src_if.ast_source_valid), 32'(vt[i].e_valid));
      check($sformatf("vec%0d_err", i),
            32'(src_if.ast_source_error), 32'(vt[i].e_err));
      check($sformatf("vec%0d_sop", i),
            32'(src_if.ast_source_sop), 32'(vt[i].e_sop));
      if (vt[i].e_valid)
        check($sformatf("vec%0d_data", i),
              32'(src_if.ast_source_data), 32'(vt[i].e_data));
    end

    // overflow: 10 pushes into 8 entries with ready low
    src_if.ast_source_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      sample_valid = 1'b1;
      sample_in = 16'(16'h0100 + i);
      step();
    end
    sample_valid = 1'b0;
    step();
    check("ovf_flag", 32'(overflow), 1);
    check("ovf_dcnt", 32'(drop_count), 2);
    check("ovf_err", 32'(src_if.ast_source_error), 1);
    check("ovf_head", 32'(src_if.ast_source_data), 32'h0100);

    // full FIFO, push and pop on the same edge
    sample_valid = 1'b1;
    sample_in = 16'h0200;
    src_if.ast_source_ready = 1'b1;
    step();
    sample_valid = 1'b0;
    check("full_pp_dcnt", 32'(drop_count), 2);
    check("full_pp_err", 32'(src_if.ast_source_error), 0);
    check("full_pp_head", 32'(src_if.ast_source_data), 32'h0101);
    n = 0;
    for (int k = 0; k < 30 && src_if.ast_source_valid; k++) begin
      n++;
      step();
    end
    check("full_pp_occ", 32'(n), 8);

    // drop counter saturation
    src_if.ast_source_ready = 1'b0;
    sample_valid = 1'b1;
    repeat (270) step();
    sample_valid = 1'b0;
    step();
    check("sat_dcnt", 32'(drop_count), 255);

    // flush overrides push and pop, clears flags
    flush = 1'b1;
    sample_valid = 1'b1;
    src_if.ast_source_ready = 1'b1;
    step();
    flush = 1'b0;
    sample_valid = 1'b0;
    check("flush_valid", 32'(src_if.ast_source_valid), 0);
    check("flush_ovf", 32'(overflow), 0);
    check("flush_dcnt", 32'(drop_count), 0);

    // framing over 130 beats
    n_sop = 0;
    n_eop = 0;
    for (int i = 0; i < 130; i++) begin
      sample_valid = 1'b1;
      sample_in = 16'(i);
      step();
    end
    sample_valid = 1'b0;
    repeat (3) step();
    check("frame_sop_cnt", 32'(n_sop), 3);
    check("frame_eop_cnt", 32'(n_eop), 2);

    // flush at beat 20 with 5 queued
    flush = 1'b1;
    step();
    flush = 1'b0;
    for (int i = 0; i < 20; i++) begin
      sample_valid = 1'b1;
      sample_in = 16'(16'h0300 + i);
      step();
    end
    sample_valid = 1'b0;
    step();
    src_if.ast_source_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sample_valid = 1'b1;
      sample_in = 16'(16'h0400 + i);
      step();
    end
    flush = 1'b1;
    src_if.ast_source_ready = 1'b1;
    step();
    flush = 1'b0;
    sample_valid = 1'b0;
    check("mid_flush_valid", 32'(src_if.ast_source_valid), 0);
    src_if.ast_source_ready = 1'b0;
    sample_valid = 1'b1;
    sample_in = 16'h0ABC;
    step();
    sample_valid = 1'b0;
    check("post_flush_sop", 32'(src_if.ast_source_sop), 1);
    check("post_flush_data", 32'(src_if.ast_source_data), 32'h0ABC);
    src_if.ast_source_ready = 1'b1;
    step();

    // reset mid-frame with overflow pending
    for (int i = 0; i < 20; i++) begin
      sample_valid = 1'b1;
      sample_in = 16'(16'h0500 + i);
      step();
    end
    sample_valid = 1'b0;
    step();
    src_if.ast_source_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      sample_valid = 1'b1;
      sample_in = 16'(16'h0600 + i);
      step();
    end
    sample_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("async_rst_valid", 32'(src_if.ast_source_valid), 0);
    step();
    check("mid_rst_ovf", 32'(overflow), 0);
    check("mid_rst_dcnt", 32'(drop_count), 0);
    check("mid_rst_err", 32'(src_if.ast_source_error), 0);
    rst = 1'b0;
    sample_valid = 1'b1;
    sample_in = 16'h0DEF;
    step();
    sample_valid = 1'b0;
    check("post_rst_sop", 32'(src_if.ast_source_sop), 1);
    check("post_rst_data", 32'(src_if.ast_source_data), 32'h0DEF);
    src_if.ast_source_ready = 1'b1;
    repeat (3) step();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fir_sample_source.md
FIR_SAMPLE_SOURCE -- requirements
Module: fir_sample_source

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, sample width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 8, FIFO entries; power of two, minimum 2.
REQ-003 The block SHALL have parameter FRAME_LEN, default 64, beats per packet; minimum 2.
REQ-004 The block SHALL have ports: clk in 1, the single clock; rst in 1, reset, asynchronous, active-high.
REQ-005 The block SHALL have ports: sample_in in DATA_W, ADC sample; sample_valid in 1, sample strobe; flush in 1, synchronous clear.
REQ-006 The block SHALL have ports: ast_source_data out DATA_W; ast_source_valid out 1; ast_source_ready in 1; ast_source_error out 2; ast_source_sop out 1; ast_source_eop out 1.
REQ-007 The block SHALL have ports: overflow out 1, sticky drop flag; drop_count out 8, saturating dropped-sample count.

Function
REQ-008 The FIFO SHALL push sample_in on a clock edge where a push is requested and (not full or a pop occurs on the same edge).
REQ-009 A push request while full with no simultaneous pop SHALL drop the sample, set overflow, increment drop_count (saturating at 255) and set the pending-error tag.
REQ-010 ast_source_valid SHALL equal FIFO not-empty; ast_source_data SHALL present the FIFO head (first-word fall-through).
REQ-011 A pop SHALL occur on an edge where ast_source_valid and ast_source_ready are both high (ready latency 0); valid and data SHALL hold while ready is low.
REQ-012 Latency SHALL be one cycle: a sample pushed into an empty FIFO at edge N SHALL be valid on the output after edge N.
REQ-013 Push and pop on the same edge SHALL leave the occupancy unchanged, including when full or when holding one entry.
REQ-014 Pointers SHALL wrap modulo DEPTH; occupancy SHALL use a log2(DEPTH)+1-bit counter.
REQ-015 The beat counter SHALL advance on each pop and wrap from FRAME_LEN-1 to 0; ast_source_sop SHALL be high when the count is 0 and ast_source_eop high when the count is FRAME_LEN-1, both qualified by ast_source_valid.
REQ-016 ast_source_error SHALL be 2'b01 on the first beat popped after a drop and 2'b00 otherwise; the tag SHALL clear on that pop unless a new drop occurs on the same edge.
REQ-017 The control FSM SHALL have states IDLE (empty, no tag), ACTIVE (not empty, no tag) and TAGGED (error pending); a drop SHALL enter TAGGED; a pop in TAGGED SHALL return to ACTIVE or IDLE according to occupancy.
REQ-018 flush SHALL empty the FIFO, zero the beat counter, clear overflow, drop_count and the tag, return to IDLE, and override a same-edge push or pop.

Reset
REQ-019 rst high SHALL asynchronously set: pointers and occupancy 0; beat count 0; FSM IDLE; ast_source_valid 0; ast_source_error 2'b00; overflow 0; drop_count 0.
REQ-020 ast_source_data SHALL reset to 0; FIFO storage SHALL NOT be reset.
REQ-021 Reset asserted mid-frame SHALL discard all queued samples; the first beat after release SHALL carry sop.

Configuration
REQ-022 With FIR_SRC_CHANGE_DETECT_EN defined, a push SHALL be requested when registered sample_in differs from its previous registered value, and sample_valid SHALL be ignored; this adds one cycle of input latency.
REQ-023 Without FIR_SRC_CHANGE_DETECT_EN, a push SHALL be requested exactly when sample_valid is high.

Structure
REQ-024 The FSM state enum, the error code constants (ERR_NONE=2'b00, ERR_OVERFLOW=2'b01) and the default widths SHALL reside in the shared package fir_pkg.
REQ-025 FIFO storage and pointers SHALL be a sub-module fir_src_fifo; framing, error tagging and the FSM SHALL reside in fir_sample_source.

Verification
REQ-026 Scenario: reset, push 0x0001..0x0003 with ready=1 -> three beats in order; first carries sop; each appears one cycle after its push; error=00.
REQ-027 Scenario: ready=0, push 10 samples at DEPTH=8 -> 8 stored; overflow=1; drop_count=2; ready=1 then -> first beat error=01, remaining 7 beats error=00.
REQ-028 Scenario: FIFO full, push and pop on the same edge -> no drop; drop_count unchanged; occupancy stays 8.
REQ-029 Scenario: stream 130 beats at FRAME_LEN=64 -> sop on beats 0, 64 and 128; eop on beats 63 and 127.
REQ-030 Scenario: flush or rst asserted at beat 20 with 5 samples queued -> valid=0 the next cycle; counters cleared; next pushed sample emits with sop.
REQ-031 Scenario: with FIR_SRC_CHANGE_DETECT_EN defined, hold sample_in=0x1234 for 5 cycles then change to 0x1235 -> exactly one push for 0x1235; held values produce no pushes.
